// File: rtl/ask_mod.sv
// On-off-keyed ASK modulator: a free-running DDS sine carrier gated by serial data bits,
// each bit held for SYM_CYCLES clocks, emitted as signed 8-bit samples two clocks later.
module ask_mod #(
  parameter int SYM_CYCLES = 8,
  parameter int PHASE_W    = 16,
  parameter int PHASE_INC  = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic              din,
  output logic              din_ready,
  output logic signed [7:0] dout,
  output logic              busy,
  output logic              sym_strobe
);

  localparam int                 CNT_W    = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SYM_CYCLES - 1);
  localparam logic [PHASE_W-1:0] INC      = PHASE_W'(PHASE_INC);

  // Two states only, so busy (registered copy of state==SEND) exposes the full FSM state.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic                bit_q, bit_next;
  logic                load;
  logic                accept;
  logic [PHASE_W-1:0]  phase;
  logic signed [7:0]   s1;
  logic                on1;

  // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64; the other three are mirrored.
  function automatic logic [6:0] quarter_sine(input logic [6:0] idx);
    case (idx)
      7'd0:    quarter_sine = 7'd0;
      7'd1:    quarter_sine = 7'd3;
      7'd2:    quarter_sine = 7'd6;
      7'd3:    quarter_sine = 7'd9;
      7'd4:    quarter_sine = 7'd12;
      7'd5:    quarter_sine = 7'd16;
      7'd6:    quarter_sine = 7'd19;
      7'd7:    quarter_sine = 7'd22;
      7'd8:    quarter_sine = 7'd25;
      7'd9:    quarter_sine = 7'd28;
      7'd10:   quarter_sine = 7'd31;
      7'd11:   quarter_sine = 7'd34;
      7'd12:   quarter_sine = 7'd37;
      7'd13:   quarter_sine = 7'd40;
      7'd14:   quarter_sine = 7'd43;
      7'd15:   quarter_sine = 7'd46;
      7'd16:   quarter_sine = 7'd49;
      7'd17:   quarter_sine = 7'd51;
      7'd18:   quarter_sine = 7'd54;
      7'd19:   quarter_sine = 7'd57;
      7'd20:   quarter_sine = 7'd60;
      7'd21:   quarter_sine = 7'd63;
      7'd22:   quarter_sine = 7'd65;
      7'd23:   quarter_sine = 7'd68;
      7'd24:   quarter_sine = 7'd71;
      7'd25:   quarter_sine = 7'd73;
      7'd26:   quarter_sine = 7'd76;
      7'd27:   quarter_sine = 7'd78;
      7'd28:   quarter_sine = 7'd81;
      7'd29:   quarter_sine = 7'd83;
      7'd30:   quarter_sine = 7'd85;
      7'd31:   quarter_sine = 7'd88;
      7'd32:   quarter_sine = 7'd90;
      7'd33:   quarter_sine = 7'd92;
      7'd34:   quarter_sine = 7'd94;
      7'd35:   quarter_sine = 7'd96;
      7'd36:   quarter_sine = 7'd98;
      7'd37:   quarter_sine = 7'd100;
      7'd38:   quarter_sine = 7'd102;
      7'd39:   quarter_sine = 7'd104;
      7'd40:   quarter_sine = 7'd106;
      7'd41:   quarter_sine = 7'd107;
      7'd42:   quarter_sine = 7'd109;
      7'd43:   quarter_sine = 7'd111;
      7'd44:   quarter_sine = 7'd112;
      7'd45:   quarter_sine = 7'd113;
      7'd46:   quarter_sine = 7'd115;
      7'd47:   quarter_sine = 7'd116;
      7'd48:   quarter_sine = 7'd117;
      7'd49:   quarter_sine = 7'd118;
      7'd50:   quarter_sine = 7'd120;
      7'd51:   quarter_sine = 7'd121;
      7'd52:   quarter_sine = 7'd122;
      7'd53:   quarter_sine = 7'd122;
      7'd54:   quarter_sine = 7'd123;
      7'd55:   quarter_sine = 7'd124;
      7'd56:   quarter_sine = 7'd125;
      7'd57:   quarter_sine = 7'd125;
      7'd58:   quarter_sine = 7'd126;
      7'd59:   quarter_sine = 7'd126;
      7'd60:   quarter_sine = 7'd126;
      7'd61:   quarter_sine = 7'd127;
      7'd62:   quarter_sine = 7'd127;
      7'd63:   quarter_sine = 7'd127;
      default: quarter_sine = 7'd127;
    endcase
  endfunction

  // Quadrants 1 and 3 read the quarter table backwards; quadrants 2 and 3 negate.
  function automatic logic signed [7:0] sine_lut(input logic [7:0] addr);
    logic [6:0] qidx;
    logic [7:0] mag;
    qidx     = addr[6] ? (7'd64 - {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
    mag      = {1'b0, quarter_sine(qidx)};
    sine_lut = addr[7] ? 8'(-$signed(mag)) : $signed(mag);
  endfunction

  // Handshake: a bit transfers on a rising clk edge where din_valid && din_ready; din_ready
  // depends only on registered state (IDLE, or last cycle of a symbol), never on din_valid.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_q;
    load       = 1'b0;
    din_ready  = (state == IDLE) || (cnt == '0);
    accept     = din_valid && din_ready;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SEND;
          load       = 1'b1;
        end
      end
      SEND: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else if (accept) begin
          load = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) begin
      cnt_next = CNT_LOAD;
      bit_next = din;
    end
  end

  // Phase is never touched by data activity so the carrier stays continuous across gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= '0;
      state      <= IDLE;
      cnt        <= '0;
      bit_q      <= 1'b0;
      busy       <= 1'b0;
      sym_strobe <= 1'b0;
      s1         <= '0;
      on1        <= 1'b0;
      dout       <= '0;
    end else begin
      phase      <= phase + INC;
      state      <= state_next;
      cnt        <= cnt_next;
      bit_q      <= bit_next;
      busy       <= (state_next == SEND);
      sym_strobe <= load;
      s1         <= sine_lut(phase[PHASE_W-1 -: 8]);
      on1        <= (state == SEND) && bit_q;
      dout       <= on1 ? s1 : 8'sd0;
    end
  end

endmodule
